// File: rtl/bin_win3_line_ctrl_pkg.sv
// Shared ISP definitions: default frame geometry, coordinate width and the
// helper that blanks window rows lying above the top of the frame.
package bin_win3_line_ctrl_pkg;

    localparam int DEF_IMG_WIDTH  = 1024;
    localparam int DEF_IMG_HEIGHT = 768;
    localparam int COORD_W        = 12;

    typedef logic [COORD_W-1:0] coord_t;

    // Rows above line 0 do not exist in this frame, so whatever the line
    // RAMs hold for them (stale data, or garbage after reset) is hidden.
    function automatic logic [2:0] maskWindow(input logic [2:0] rawCol, input coord_t rowY);
        logic [2:0] masked;
        masked = rawCol;
        if (rowY == '0) begin
            masked[2:1] = 2'b00;
        end else if (rowY == coord_t'(1)) begin
            masked[2] = 1'b0;
        end
        return masked;
    endfunction

endpackage

// File: rtl/bin_win3_line_ctrl_ram.sv
// Single-bit line buffer with one write port and a registered read port.
// Reads are read-first: a read and a write to the same address in one cycle
// return the old contents. The storage itself is never reset.
module line_ram_1b
    import bin_win3_line_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_we,
    input  coord_t i_waddr,
    input  logic   i_wdata,
    input  logic   i_re,
    input  coord_t i_raddr,
    output logic   o_rdata
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic        r_mem [DEPTH];
    logic        r_rdata;
    logic        w_wrHit;
    logic        w_rdHit;
    logic [31:0] w_waddrWide;
    logic [31:0] w_raddrWide;

    assign w_waddrWide = {{(32-COORD_W){1'b0}}, i_waddr};
    assign w_raddrWide = {{(32-COORD_W){1'b0}}, i_raddr};
    assign w_wrHit     = i_we && (w_waddrWide < DEPTH_U);
    assign w_rdHit     = w_raddrWide < DEPTH_U;
    assign o_rdata     = r_rdata;

    // Storage write; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (w_wrHit) begin
            r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end

    // Registered read, holding its value on cycles with no read request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 1'b0;
        end else if (i_re) begin
            r_rdata <= w_rdHit ? r_mem[i_raddr[IDX_W-1:0]] : 1'b0;
        end
    end

endmodule

// File: rtl/bin_win3_line_ctrl.sv
// 3-row binary window column generator: for each accepted pixel it emits,
// one cycle later, the pixel plus the two pixels directly above it, taken
// from two cascaded line buffers (A = previous row, B = the row before).
module bin_win3_line_ctrl
    import bin_win3_line_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    input  logic       i_in_sof,
    input  logic       i_in_data,
    output logic       o_col_valid,
    output logic [2:0] o_col_data,
    output coord_t     o_col_x,
    output coord_t     o_col_y,
    output logic       o_rows_ok,
    output logic       o_frame_done,
    output logic       o_sof_err
);

    localparam coord_t LAST_X = coord_t'(IMG_WIDTH - 1);
    localparam coord_t LAST_Y = coord_t'(IMG_HEIGHT - 1);

    coord_t r_x;
    coord_t r_y;
    logic   r_s1Valid;
    coord_t r_s1X;
    coord_t r_s1Y;
    logic   r_s1Data;
    logic   r_frameDone;
    logic   r_sofErr;

    coord_t w_curX;
    coord_t w_curY;
    coord_t w_nextX;
    coord_t w_nextY;
    logic   w_ramAOut;
    logic   w_ramBOut;

    // Position of the incoming pixel (sof forces the origin) and the raster position after it.
    always_comb begin
        w_curX  = i_in_sof ? '0 : r_x;
        w_curY  = i_in_sof ? '0 : r_y;
        w_nextX = w_curX + coord_t'(1);
        w_nextY = w_curY;
        if (w_curX == LAST_X) begin
            w_nextX = '0;
            w_nextY = (w_curY == LAST_Y) ? '0 : (w_curY + coord_t'(1));
        end
    end

    // Raster counters advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_in_valid) begin
            r_x <= w_nextX;
            r_y <= w_nextY;
        end
    end

    // Stage 1 captures the pixel and its position while the line RAMs read that column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid   <= 1'b0;
            r_s1X       <= '0;
            r_s1Y       <= '0;
            r_s1Data    <= 1'b0;
            r_frameDone <= 1'b0;
            r_sofErr    <= 1'b0;
        end else begin
            r_s1Valid   <= i_in_valid;
            r_frameDone <= i_in_valid && (w_curX == LAST_X) && (w_curY == LAST_Y);
            r_sofErr    <= i_in_valid && i_in_sof && ((r_x != '0) || (r_y != '0));
            if (i_in_valid) begin
                r_s1X    <= w_curX;
                r_s1Y    <= w_curY;
                r_s1Data <= i_in_data;
            end
        end
    end

    // Row y-1: written with the current pixel one cycle after it was read.
    line_ram_1b #(.DEPTH(IMG_WIDTH)) u_ramA (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_s1Valid),
        .i_waddr (r_s1X),
        .i_wdata (r_s1Data),
        .i_re    (i_in_valid),
        .i_raddr (w_curX),
        .o_rdata (w_ramAOut)
    );

    // Row y-2: inherits whatever RAM A just handed out for the same column.
    line_ram_1b #(.DEPTH(IMG_WIDTH)) u_ramB (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_s1Valid),
        .i_waddr (r_s1X),
        .i_wdata (w_ramAOut),
        .i_re    (i_in_valid),
        .i_raddr (w_curX),
        .o_rdata (w_ramBOut)
    );

    assign o_col_valid  = r_s1Valid;
    assign o_col_data   = maskWindow({w_ramBOut, w_ramAOut, r_s1Data}, r_s1Y);
    assign o_col_x      = r_s1X;
    assign o_col_y      = r_s1Y;
    assign o_rows_ok    = (r_s1Y >= coord_t'(2));
    assign o_frame_done = r_frameDone;
    assign o_sof_err    = r_sofErr;

endmodule

// File: doc/bin_win3_line_ctrl.md
BIN_WIN3_LINE_CTRL -- requirements
Module: bin_win3_line_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 1024, SHALL set the pixels per line, legal range 2..4096.
REQ-002 Parameter IMG_HEIGHT, default 768, SHALL set the lines per frame, legal range 3..4096.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  input  1  SHALL qualify in_data and in_sof; one binary pixel per asserted cycle.
REQ-006 in_sof  input  1  SHALL mark the pixel at x=0, y=0 of a frame.
REQ-007 in_data  input  1  SHALL carry the binary pixel value.
REQ-008 col_valid  output  1  SHALL qualify col_data, col_x, col_y, rows_ok.
REQ-009 col_data  output  3  SHALL carry one window column: bit2 = row y-2, bit1 = row y-1, bit0 = row y, all at column col_x.
REQ-010 col_x / col_y  output  12 each  SHALL give the coordinates of the col_data bit0 pixel.
REQ-011 rows_ok  output  1  SHALL be high when col_y >= 2, meaning all three rows hold valid frame data.
REQ-012 frame_done  output  1  SHALL pulse for one cycle together with the column for x=IMG_WIDTH-1, y=IMG_HEIGHT-1.
REQ-013 sof_err  output  1  SHALL pulse for one cycle when in_sof arrives while the counters are not at x=0, y=0.

Function
REQ-014 Column counter x and row counter y (12 bit) SHALL advance only on in_valid; in_valid low SHALL stall all state, with no RAM write and col_valid low.
REQ-015 x SHALL wrap IMG_WIDTH-1 -> 0 and increment y; y SHALL wrap IMG_HEIGHT-1 -> 0 at that same pixel.
REQ-016 A pixel with in_sof SHALL be treated as x=0, y=0 regardless of counter state; the counters then continue from x=1, y=0.
REQ-017 Two 1-bit line RAMs SHALL be used, each with registered read and 1-cycle read latency: RAM A holds row y-1, RAM B holds row y-2.
REQ-018 Cycle t (in_valid): RAM A and RAM B raddr = x; x, y and in_data SHALL be registered into stage 1.
REQ-019 Cycle t+1: RAM A SHALL write stage-1 in_data at stage-1 x, and RAM B SHALL write RAM A's read output at stage-1 x (en = stage-1 valid).
REQ-020 Cycle t+1: col_valid SHALL be high with col_data = {RAM B out, RAM A out, stage-1 in_data}; total latency is exactly 1 cycle.
REQ-021 For col_y = 0, bits 2 and 1 SHALL be forced to 0; for col_y = 1, bit 2 SHALL be forced to 0; rows_ok SHALL be 0 in both cases.
REQ-022 Back-to-back in_valid at full rate SHALL be sustained with no bubbles.
REQ-023 When sof arrives mid-frame, the block SHALL pulse sof_err at t+1 and restart at y=0; the forcing in REQ-021 then applies to rows 0 and 1.
REQ-024 frame_done and sof_err SHALL be registered and aligned with the col_valid of the triggering pixel.

Reset
REQ-025 On rst_n low: x, y, stage registers, col_valid, col_data, col_x, col_y, rows_ok, frame_done and sof_err SHALL all be 0, and RAM read registers SHALL be 0.
REQ-026 RAM contents SHALL NOT be cleared by reset; correctness after reset SHALL rely only on REQ-021 forcing.
REQ-027 Reset asserted mid-frame SHALL drop col_valid immediately; after release, the first accepted pixel SHALL be treated as x=0, y=0 even without in_sof.

Structure
REQ-028 IMG_WIDTH/IMG_HEIGHT defaults and the 12-bit coordinate width SHALL reside in the shared ISP package.
REQ-029 The line RAM SHALL be a sub-module line_ram_1b (depth IMG_WIDTH, 12-bit addresses, write enable, registered read), instantiated twice.

Verification
REQ-030 4x3 frame, pixel = x XOR y, continuous valid -> 12 col_valid pulses; at (x=2, y=2) col_data = {0,1,0}, rows_ok=1; frame_done pulses on (3,2).
REQ-031 in_valid toggled 1/0 every cycle -> output sequence identical to REQ-030 apart from timing; no writes on idle cycles.
REQ-032 Rows 0 and 1 all ones -> every column with y=0 gives col_data=3'b001; every column with y=1 gives 3'b011.
REQ-033 in_sof injected at x=2, y=1 of a 4x3 frame -> sof_err pulse on that column; col_x=0, col_y=0, col_data=3'b00d.
REQ-034 rst_n pulsed low at x=1, y=2, then frame restarted -> all outputs 0 during reset; first post-reset column has col_x=0, col_y=0, rows_ok=0.
REQ-035 IMG_WIDTH=1024 full frame of random pixels -> col_data bits 2 and 1 match a reference model's rows y-2 and y-1 for every column with rows_ok=1.
